// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: data width, cache geometry, FSM states.
package riscv_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned ICACHE_LINES = 32;
    localparam int unsigned INDEX_W      = $clog2(ICACHE_LINES);
    localparam int unsigned TAG_W        = XLEN - 2 - INDEX_W;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } fetch_state_t;

endpackage

// File: rtl/fetcher_if.sv
// Fetch-stage bus: memory request/return, issue output, ROB redirect.
interface fetcher_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] pc_to_mem;
    logic            en_to_mem;
    logic            drop_flag_to_mem;
    logic            done_flag_from_mem;
    logic [XLEN-1:0] inst_from_mem;
    logic            stall_from_issue;
    logic            inst_valid_to_issue;
    logic [XLEN-1:0] inst_to_issue;
    logic [XLEN-1:0] pc_to_issue;
    logic            flush_from_rob;
    logic [XLEN-1:0] target_pc_from_rob;

    modport master (
        output pc_to_mem, en_to_mem, drop_flag_to_mem,
        output inst_valid_to_issue, inst_to_issue, pc_to_issue,
        input  done_flag_from_mem, inst_from_mem, stall_from_issue,
        input  flush_from_rob, target_pc_from_rob
    );

    modport slave (
        input  pc_to_mem, en_to_mem, drop_flag_to_mem,
        input  inst_valid_to_issue, inst_to_issue, pc_to_issue,
        output done_flag_from_mem, inst_from_mem, stall_from_issue,
        output flush_from_rob, target_pc_from_rob
    );

endinterface

// File: rtl/fetcher_icache.sv
// Direct-mapped one-word-per-line instruction cache, addressed by word (pc[31:2]).
module icache import riscv_pkg::*; #(
    parameter int unsigned LINES = ICACHE_LINES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-3:0] lookup_word,
    output logic            hit,
    output logic [XLEN-1:0] hit_data,
    input  logic            fill_en,
    input  logic [XLEN-3:0] fill_word,
    input  logic [XLEN-1:0] fill_data
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = XLEN - 2 - IW;

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags  [LINES];
    logic [XLEN-1:0]  lines [LINES];

    logic [IW-1:0] lookup_idx;
    logic [TW-1:0] lookup_tag;
    logic [IW-1:0] fill_idx;
    logic [TW-1:0] fill_tag;

    assign lookup_idx = lookup_word[IW-1:0];
    assign lookup_tag = lookup_word[XLEN-3:IW];
    assign fill_idx   = fill_word[IW-1:0];
    assign fill_tag   = fill_word[XLEN-3:IW];

    assign hit      = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);
    assign hit_data = lines[lookup_idx];

    // Valid bits: cleared asynchronously on reset, set on fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data storage: written on fill only, contents meaningless while invalid.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[fill_idx]  <= fill_tag;
            lines[fill_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch: cache lookup, single outstanding miss, ROB redirect.
module fetcher import riscv_pkg::*; #(
    parameter int unsigned ICACHE_LINES = riscv_pkg::ICACHE_LINES
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    fetcher_if.master bus
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] pc_mem_q, pc_mem_next;
    logic            en_q, en_next;
    logic            drop_q, drop_next;
    logic            iv_q, iv_next;
    logic [XLEN-1:0] inst_q, inst_next;
    logic [XLEN-1:0] pc_issue_q, pc_issue_next;
    logic            fill_req;
    logic            hit;
    logic [XLEN-1:0] hit_data;

    icache #(.LINES(ICACHE_LINES)) u_icache (
        .clk         (clk_in),
        .rst_n       (rst_in),
        .lookup_word (pc[XLEN-1:2]),
        .hit         (hit),
        .hit_data    (hit_data),
        .fill_en     (fill_req && rdy_in),
        .fill_word   (pc[XLEN-1:2]),
        .fill_data   (bus.inst_from_mem)
    );

    assign bus.pc_to_mem           = pc_mem_q;
    assign bus.en_to_mem           = en_q;
    assign bus.drop_flag_to_mem    = drop_q;
    assign bus.inst_valid_to_issue = iv_q;
    assign bus.inst_to_issue       = inst_q;
    assign bus.pc_to_issue         = pc_issue_q;

    // Next-state and registered-output decode; flush overrides everything except a same-cycle fill.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        pc_mem_next   = pc_mem_q;
        en_next       = 1'b0;
        drop_next     = 1'b0;
        iv_next       = 1'b0;
        inst_next     = inst_q;
        pc_issue_next = pc_issue_q;
        fill_req      = 1'b0;
        if (bus.flush_from_rob) begin
            pc_next    = bus.target_pc_from_rob;
            state_next = IDLE;
            if (state == WAIT_MEM) begin
                if (bus.done_flag_from_mem) fill_req  = 1'b1;
                else                        drop_next = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        en_next     = 1'b1;
                        pc_mem_next = pc;
                        state_next  = WAIT_MEM;
                    end else if (!bus.stall_from_issue) begin
                        iv_next       = 1'b1;
                        inst_next     = hit_data;
                        pc_issue_next = pc;
                        pc_next       = pc + 32'd4;
                    end
                end
                WAIT_MEM: begin
                    if (bus.done_flag_from_mem) begin
                        fill_req   = 1'b1;
                        state_next = IDLE;
                        if (!bus.stall_from_issue) begin
                            iv_next       = 1'b1;
                            inst_next     = bus.inst_from_mem;
                            pc_issue_next = pc;
                            pc_next       = pc + 32'd4;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            pc         <= '0;
            pc_mem_q   <= '0;
            en_q       <= 1'b0;
            drop_q     <= 1'b0;
            iv_q       <= 1'b0;
            inst_q     <= '0;
            pc_issue_q <= '0;
        end else if (rdy_in) begin
            state      <= state_next;
            pc         <= pc_next;
            pc_mem_q   <= pc_mem_next;
            en_q       <= en_next;
            drop_q     <= drop_next;
            iv_q       <= iv_next;
            inst_q     <= inst_next;
            pc_issue_q <= pc_issue_next;
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Randomized self-checking bench for fetcher against a transaction-level model.
module tb_fetcher;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;

    fetcher_if bus();

    fetcher #(.ICACHE_LINES(32)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: fetch pointer, one-miss-outstanding flag, cache as plain arrays.
    logic [31:0] m_pc;
    bit          m_wait;
    bit          c_valid [32];
    logic [31:0] c_tag   [32];
    logic [31:0] c_data  [32];
    logic [31:0] e_pc_mem, e_inst, e_ipc;
    logic        e_en, e_drop, e_iv;

    // Memory responder and stimulus state.
    int unsigned mem_cnt, stale_cnt, stall_run;
    logic [31:0] mem_addr;
    logic        in_done, in_stall, in_flush;
    logic [31:0] in_inst, in_target;
    bit          pending;
    bit          did_reset;

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 4) % 32;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / 128;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        m_pc = '0;
        m_wait = 0;
        for (int i = 0; i < 32; i++) c_valid[i] = 0;
        e_pc_mem = '0; e_inst = '0; e_ipc = '0;
        e_en = 0; e_drop = 0; e_iv = 0;
        mem_cnt = 0; stale_cnt = 0; stall_run = 0;
        pending = 0;
    endtask

    task automatic model_fill(input logic [31:0] data);
        c_valid[idx_of(m_pc)] = 1;
        c_tag[idx_of(m_pc)]   = tag_of(m_pc);
        c_data[idx_of(m_pc)]  = data;
    endtask

    task automatic model_issue(input logic [31:0] data);
        e_iv  = 1;
        e_inst = data;
        e_ipc = m_pc;
        m_pc  = m_pc + 32'd4;
    endtask

    // One active clock of the fetch rules, using the inputs about to be applied.
    task automatic model_step();
        bit hit;
        hit = c_valid[idx_of(m_pc)] && (c_tag[idx_of(m_pc)] == tag_of(m_pc));
        e_en = 0; e_drop = 0; e_iv = 0;
        if (in_flush) begin
            if (m_wait && in_done) model_fill(in_inst);
            if (m_wait && !in_done) begin
                e_drop = 1;
                mem_cnt = 0;
                stale_cnt = $urandom_range(1, 4);
            end
            m_wait = 0;
            m_pc = in_target;
        end else if (!m_wait) begin
            if (!hit) begin
                e_en = 1;
                e_pc_mem = m_pc;
                m_wait = 1;
                mem_addr = m_pc;
                mem_cnt = $urandom_range(1, 5);
            end else if (!in_stall) begin
                model_issue(c_data[idx_of(m_pc)]);
            end
        end else if (in_done) begin
            model_fill(in_inst);
            m_wait = 0;
            if (!in_stall) model_issue(in_inst);
        end
    endtask

    task automatic gen_inputs();
        logic [31:0] tgts [6];
        int unsigned sel;
        tgts = '{32'h0, 32'h8, 32'h80, 32'h100, 32'hFFFF_FFF8, 32'h40};
        in_done = 0;
        in_inst = $urandom;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                in_done = 1;
                in_inst = mem_word(mem_addr);
            end
        end else if (stale_cnt > 0) begin
            stale_cnt--;
            if (stale_cnt == 0 && !m_wait) in_done = 1;
        end
        if (stall_run > 0) begin
            stall_run--;
            in_stall = 1;
        end else begin
            in_stall = 0;
            if ($urandom_range(0, 11) == 0) stall_run = $urandom_range(1, 6);
        end
        in_flush = ($urandom_range(0, 13) == 0);
        sel = $urandom_range(0, 6);
        if (sel == 6) in_target = $urandom & 32'h0000_01FC;
        else          in_target = tgts[sel];
    endtask

    task automatic drive();
        bus.done_flag_from_mem = in_done;
        bus.inst_from_mem      = in_inst;
        bus.stall_from_issue   = in_stall;
        bus.flush_from_rob     = in_flush;
        bus.target_pc_from_rob = in_target;
    endtask

    task automatic compare_outputs(input string when);
        check({when, ":inst_valid"}, {31'd0, bus.inst_valid_to_issue}, {31'd0, e_iv});
        check({when, ":inst"},       bus.inst_to_issue,                e_inst);
        check({when, ":pc_issue"},   bus.pc_to_issue,                  e_ipc);
        check({when, ":en_to_mem"},  {31'd0, bus.en_to_mem},           {31'd0, e_en});
        check({when, ":pc_to_mem"},  bus.pc_to_mem,                    e_pc_mem);
        check({when, ":drop"},       {31'd0, bus.drop_flag_to_mem},    {31'd0, e_drop});
    endtask

    initial begin
        rst_n = 1'b0;
        rdy = 1'b1;
        in_done = 0; in_inst = '0; in_stall = 0; in_flush = 0; in_target = '0;
        drive();
        model_reset();
        did_reset = 0;
        repeat (3) @(negedge clk);
        compare_outputs("reset");
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!pending) gen_inputs();
            drive();
            rdy = ($urandom_range(0, 9) != 0);
            pending = !rdy;
            if (rdy) model_step();
            @(negedge clk);
            compare_outputs("run");
            // Reset while a miss is outstanding: request abandoned silently.
            if (!did_reset && cyc >= 2000 && m_wait) begin
                did_reset = 1;
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_outputs("midreset");
                in_done = 0; in_flush = 0; in_stall = 0;
                drive();
                @(negedge clk);
                compare_outputs("midreset_hold");
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 clk_in  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_in  input  1  reset, asynchronous, active-low; 0 forces reset state immediately.
REQ-003 rdy_in  input  1  global ready; 0 freezes all state and holds all outputs.
REQ-004 pc_to_mem  output  32  fetch address presented to memory controller.
REQ-005 en_to_mem  output  1  one-cycle fetch request pulse.
REQ-006 drop_flag_to_mem  output  1  one-cycle pulse cancelling the outstanding fetch.
REQ-007 done_flag_from_mem  input  1  one-cycle pulse; inst_from_mem valid.
REQ-008 inst_from_mem  input  32  fetched instruction word.
REQ-009 stall_from_issue  input  1  downstream full; no instruction may be issued while 1.
REQ-010 inst_valid_to_issue  output  1  one-cycle pulse; inst/pc outputs valid.
REQ-011 inst_to_issue  output  32  issued instruction.
REQ-012 pc_to_issue  output  32  address of issued instruction.
REQ-013 flush_from_rob  input  1  redirect request; highest priority.
REQ-014 target_pc_from_rob  input  32  redirect address, sampled when flush_from_rob=1.
REQ-015 Parameter ICACHE_LINES, default 32, number of one-word direct-mapped cache lines.

Function
REQ-016 Cache indexing SHALL use index=pc[6:2], tag=pc[31:7], one valid bit per line; pc[1:0] ignored.
REQ-017 The state machine SHALL have states IDLE and WAIT_MEM.
REQ-018 IDLE, no flush, stall=0, cache hit: next edge SHALL drive inst_valid_to_issue=1 with line data and current pc, pc <= pc+4 (32-bit wrap, 0xFFFFFFFC -> 0x0).
REQ-019 IDLE, no flush, cache miss (independent of stall): next edge SHALL pulse en_to_mem=1 with pc_to_mem=pc for exactly one cycle and enter WAIT_MEM.
REQ-020 IDLE, stall=1, hit: no issue, pc held, state held.
REQ-021 WAIT_MEM: en_to_mem SHALL stay 0; no new request until return to IDLE.
REQ-022 WAIT_MEM, done_flag_from_mem=1, no flush: fill line (valid=1, tag, data) and return to IDLE; if stall=0 also issue inst_from_mem with pc and pc <= pc+4 on same edge; if stall=1 no issue, pc held (later hit issues it).
REQ-023 flush_from_rob=1 in any state: pc <= target_pc_from_rob, inst_valid_to_issue <= 0, state <= IDLE; no issue or new request that cycle.
REQ-024 flush in WAIT_MEM without done: drop_flag_to_mem SHALL pulse 1 for one cycle.
REQ-025 flush and done same cycle: cache fill SHALL still occur, no issue, drop_flag_to_mem SHALL stay 0.
REQ-026 done_flag_from_mem in IDLE (stale, post-drop) SHALL be ignored: no fill, no issue.
REQ-027 inst_valid_to_issue, en_to_mem, drop_flag_to_mem SHALL be single-cycle pulses, cleared every active cycle unless re-asserted.
REQ-028 Hit latency 1 cycle; miss-to-issue latency = memory latency + 1 cycle.

Reset
REQ-029 Reset SHALL set pc=0x00000000, state=IDLE, all cache valid bits=0.
REQ-030 Reset SHALL drive all outputs to 0: pc_to_mem, en_to_mem, drop_flag_to_mem, inst_valid_to_issue, inst_to_issue, pc_to_issue.
REQ-031 Reset asserted during WAIT_MEM SHALL abandon the request without drop pulse; first post-reset fetch misses at 0x0.

Structure
REQ-032 Shared package riscv_pkg SHALL hold ICACHE_LINES, index/tag widths, state encodings, XLEN=32.
REQ-033 Cache storage (valid, tag, data arrays; combinational lookup, synchronous fill, async clear) SHALL be sub-module icache; control FSM stays in fetcher.

Verification
REQ-034 Cold start: reset, mem returns 0x00000013 at 0x0 after 4 cycles -> en_to_mem pulse pc_to_mem=0x0, issue pc=0x0 inst=0x00000013, pc=0x4.
REQ-035 Loop: flush target 0x0 after 0x0 filled -> issue pc=0x0 exactly 1 cycle after flush, en_to_mem stays 0.
REQ-036 Flush target 0x100 mid-miss at 0x8 -> drop_flag_to_mem one pulse, next request pc_to_mem=0x100, late done for 0x8 ignored.
REQ-037 stall=1 for 5 cycles during hits -> no issue, pc held; release -> issue resumes in order, no duplicates or skips.
REQ-038 Conflict: fetch 0x0 then 0x80 (same index 0) -> second misses and evicts; refetch 0x0 misses again.
REQ-039 rdy_in=0 for 3 cycles with done pulse held -> state and outputs frozen; fill and issue occur on the first cycle with rdy_in=1.
